cby_param: RTL and testbench

CBY_PARAM -- requirements
Module: cby_param

---
 rtl/cby_param.sv | 73 +++++++
 tb/tb_cby_param.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cby_param.sv
// cby_param: Y-channel connection block with scan-chain configured IPIN muxes and pass-through tracks.
module cby_param #(
    parameter int CHAN_W       = 9,
    parameter int N_IPIN       = 10,
    parameter int MUX_SIZE     = 6,
    parameter int TRACK_STRIDE = 4,
    parameter int OUT_REG      = 0
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chany_top_in,
    input  logic              ccff_head,
    input  logic              ccff_en,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [N_IPIN-1:0] ipin_out,
    output logic              ccff_tail,
    output logic              cfg_done
);
    localparam int SEL_W    = $clog2(MUX_SIZE);
    localparam int CFG_BITS = N_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(MUX_SIZE);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              r_state, w_nstate;
    logic [CNT_W-1:0]    r_cnt, w_ncnt;
    logic [CFG_BITS-1:0] r_chain;
    logic [N_IPIN-1:0]   w_mux, w_gated;
    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;
    assign ccff_tail        = r_chain[CFG_BITS-1];
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_chain <= '0;
        end else if (ccff_en) begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_chain <= {r_chain[CFG_BITS-2:0], ccff_head};
        end
    end
    // every enabled shift lands in SHIFT unless it completes the chain
    always_comb begin
        w_nstate = (r_state == SHIFT && r_cnt == CNT_W'(CFG_BITS - 1)) ? DONE : SHIFT;
        w_ncnt   = (r_state == SHIFT) ? r_cnt + 1'b1 : CNT_W'(1);
    end
    always_comb begin
        cfg_done = (r_state == DONE);
    end
    for (genvar k = 0; k < N_IPIN; k++) begin : g_ipin
        logic [MUX_SIZE-1:0] w_in;
        logic [SEL_W-1:0]    w_sel;
        for (genvar m = 0; m < MUX_SIZE / 2; m++) begin : g_pair
            localparam int T = (k + m * TRACK_STRIDE) % CHAN_W;
            assign w_in[2*m]   = chany_bottom_in[T];
            assign w_in[2*m+1] = chany_top_in[T];
        end
        assign w_sel    = r_chain[k*SEL_W +: SEL_W];
        assign w_mux[k] = ({1'b0, w_sel} < SEL_LIM) ? w_in[w_sel] : 1'b0;
    end
    assign w_gated = w_mux & {N_IPIN{cfg_done}};
    if (OUT_REG != 0) begin : g_reg
        logic [N_IPIN-1:0] r_ipin;
        always_ff @(posedge prog_clk) begin
            r_ipin <= prog_reset ? '0 : w_gated;
        end
        assign ipin_out = r_ipin;
    end else begin : g_comb
        assign ipin_out = w_gated;
    end
endmodule

// File: tb/tb_cby_param.sv
// tb_cby_param: directed vector table plus corner-case sequences for cby_param (combinational and registered outputs).
module tb_cby_param;
    logic       clk = 1'b0;
    logic       rst, head, en;
    logic [8:0] bot, top;
    logic [8:0] top_out0, bot_out0, top_out1, bot_out1;
    logic [9:0] ipin0, ipin1;
    logic       tail0, tail1, done0, done1;
    int         n_cmp = 0;
    int         n_bad = 0;
    typedef struct {
        logic [29:0] cfg;
        logic [8:0]  bot;
        logic [8:0]  top;
        logic [9:0]  exp;
    } vec_t;
    vec_t v[9];
    localparam logic [29:0] CFG_A = 30'o1111111111;
    localparam logic [29:0] CFG_H = 30'o1111111117;
    always #5 clk = ~clk;
    cby_param #(.OUT_REG(0)) dut0 (
        .prog_clk(clk), .prog_reset(rst), .chany_bottom_in(bot), .chany_top_in(top),
        .ccff_head(head), .ccff_en(en), .chany_bottom_out(bot_out0), .chany_top_out(top_out0),
        .ipin_out(ipin0), .ccff_tail(tail0), .cfg_done(done0)
    );
    cby_param #(.OUT_REG(1)) dut1 (
        .prog_clk(clk), .prog_reset(rst), .chany_bottom_in(bot), .chany_top_in(top),
        .ccff_head(head), .ccff_en(en), .chany_bottom_out(bot_out1), .chany_top_out(top_out1),
        .ipin_out(ipin1), .ccff_tail(tail1), .cfg_done(done1)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic shift_bits(input logic [29:0] c, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            head = c[i];
            en   = 1'b1;
            tick();
        end
        en   = 1'b0;
        head = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        v[0] = '{CFG_A,          9'h1FF, 9'h0A5, 10'h2A5};
        v[1] = '{30'o0000000000, 9'h13C, 9'h1FF, 10'h13C};
        v[2] = '{30'o7777777777, 9'h1FF, 9'h1FF, 10'h000};
        v[3] = '{30'o2222222222, 9'h001, 9'h1FF, 10'h020};
        v[4] = '{30'o5555555555, 9'h1FF, 9'h002, 10'h004};
        v[5] = '{30'o3333333333, 9'h000, 9'h100, 10'h010};
        v[6] = '{30'o0000000004, 9'h100, 9'h000, 10'h101};
        v[7] = '{CFG_H,          9'h1FF, 9'h1FF, 10'h3FE};
        v[8] = '{30'o6666666666, 9'h1FF, 9'h1FF, 10'h000};
        rst = 1'b0; head = 1'b0; en = 1'b0; bot = '0; top = '0;
        tick();
        do_reset();
        bot = 9'h1FF;
        top = 9'h000;
        #1;
        chk("rst_top_out", 32'(top_out0), 32'h1FF);
        chk("rst_bot_out", 32'(bot_out0), 32'h000);
        chk("rst_ipin0", 32'(ipin0), 32'h0);
        chk("rst_ipin1", 32'(ipin1), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_tail", 32'(tail0), 32'h0);
        top = 9'h0A5;
        shift_bits(CFG_A, 29, 1);
        chk("load29_done", 32'(done0), 32'h0);
        chk("load29_ipin", 32'(ipin0), 32'h0);
        shift_bits(CFG_A, 0, 0);
        chk("load30_done", 32'(done0), 32'h1);
        chk("load30_ipin", 32'(ipin0), 32'h2A5);
        for (int i = 0; i < 9; i++) begin
            shift_bits(v[i].cfg, 29, 0);
            bot = v[i].bot;
            top = v[i].top;
            #1;
            chk($sformatf("vec%0d_ipin", i), 32'(ipin0), 32'(v[i].exp));
            chk($sformatf("vec%0d_done", i), 32'(done0), 32'h1);
            chk($sformatf("vec%0d_tail", i), 32'(tail0), 32'(v[i].cfg[29]));
            chk($sformatf("vec%0d_pass", i), 32'({top_out0, bot_out0}), 32'({v[i].bot, v[i].top}));
            tick();
            chk($sformatf("vec%0d_ipin_reg", i), 32'(ipin1), 32'(v[i].exp));
        end
        do_reset();
        bot = 9'h1FF;
        top = 9'h1FF;
        shift_bits(CFG_H, 29, 15);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("gap%0d_done", i), 32'(done0), 32'h0);
        end
        shift_bits(CFG_H, 14, 0);
        chk("gap_done", 32'(done0), 32'h1);
        chk("gap_ipin", 32'(ipin0), 32'h3FE);
        chk("gap_tail", 32'(tail0), 32'h0);
        shift_bits(30'o7111111111, 29, 0);
        #1;
        chk("recfg_ipin_before", 32'(ipin0), 32'h1FF);
        tick();
        chk("recfg_ipin_reg_before", 32'(ipin1), 32'h1FF);
        shift_bits(30'h3FFFFFFF, 0, 0);
        chk("recfg_done", 32'(done0), 32'h0);
        chk("recfg_ipin", 32'(ipin0), 32'h0);
        chk("recfg_tail", 32'(tail0), 32'h1);
        chk("recfg_ipin_reg_lag", 32'(ipin1), 32'h1FF);
        tick();
        chk("recfg_ipin_reg", 32'(ipin1), 32'h0);
        shift_bits(30'h3FFFFFFF, 29, 15);
        do_reset();
        chk("midrst_done", 32'(done0), 32'h0);
        chk("midrst_tail", 32'(tail0), 32'h0);
        top = 9'h0A5;
        shift_bits(CFG_A, 29, 15);
        chk("midrst_chain_clear", 32'(tail0), 32'h0);
        shift_bits(CFG_A, 14, 1);
        chk("midrst_done29", 32'(done0), 32'h0);
        shift_bits(CFG_A, 0, 0);
        chk("midrst_done30", 32'(done0), 32'h1);
        chk("midrst_ipin", 32'(ipin0), 32'h2A5);
        chk("midrst_ipin_reg_lat0", 32'(ipin1), 32'h0);
        chk("midrst_done_reg", 32'(done1), 32'h1);
        tick();
        chk("midrst_ipin_reg_lat1", 32'(ipin1), 32'h2A5);
        top = 9'h1FF;
        #1;
        chk("inchg_ipin", 32'(ipin0), 32'h3FF);
        chk("inchg_ipin_reg_lag", 32'(ipin1), 32'h2A5);
        tick();
        chk("inchg_ipin_reg", 32'(ipin1), 32'h3FF);
        rst  = 1'b1;
        en   = 1'b1;
        head = 1'b1;
        tick();
        rst  = 1'b0;
        en   = 1'b0;
        head = 1'b0;
        chk("prio_done", 32'(done0), 32'h0);
        chk("prio_tail", 32'(tail0), 32'h0);
        chk("prio_ipin_reg", 32'(ipin1), 32'h0);
        shift_bits(CFG_A, 29, 1);
        chk("prio_done29", 32'(done0), 32'h0);
        shift_bits(CFG_A, 0, 0);
        chk("prio_done30", 32'(done0), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
